// File: rtl/pe_fu_multi_pkg.sv
// Shared types for the PE functional unit: opcodes, FSM states, cfg word layout.
// Optional multiplier is governed by PE_FU_MUL_EN.
package pe_fu_pkg;

    localparam int IMM_WIDTH      = 16;
    localparam int CFG_OP_LSB     = 0;
    localparam int CFG_OP_WIDTH   = 4;
    localparam int CFG_IMM_EN_BIT = 4;
    localparam int CFG_ACC_EN_BIT = 5;
    localparam int CFG_IMM_LSB    = 16;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SHL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_LT    = 4'd8,
        OP_LTU   = 4'd9,
        OP_EQ    = 4'd10,
        OP_SEL   = 4'd11,
        OP_MUL   = 4'd12,
        OP_RSV13 = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } fu_op_e;

    typedef enum logic {
        ST_UNCFG = 1'b0,
        ST_RUN   = 1'b1
    } fu_state_e;

    typedef struct packed {
        logic [IMM_WIDTH-1:0] imm;
        logic                 acc_en;
        logic                 imm_en;
        fu_op_e               op;
    } cfg_t;

    function automatic logic op_legal(input fu_op_e op);
`ifdef PE_FU_MUL_EN
        return (op <= OP_MUL);
`else
        return (op < OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/pe_fu_multi_if.sv
// Token/config bundle between PE input logic, the functional unit and the output channel.
interface pe_fu_multi_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 3
);
    logic                         cfg_valid;
    logic [DATA_WIDTH-1:0]        cfg;
    logic                         cfg_err;
    logic                         clear;
    logic [NUM_IN-1:0]            in_valid;
    logic [NUM_IN*DATA_WIDTH-1:0] in_data;
    logic                         in_last;
    logic [NUM_IN-1:0]            fu_ready;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        fu_out;
    logic                         fu_valid;
    logic                         fu_alloc;
    logic                         fu_done;

    modport master (
        output cfg_valid, cfg, clear, in_valid, in_data, in_last, out_ready,
        input  cfg_err, fu_ready, fu_out, fu_valid, fu_alloc, fu_done
    );

    modport slave (
        input  cfg_valid, cfg, clear, in_valid, in_data, in_last, out_ready,
        output cfg_err, fu_ready, fu_out, fu_valid, fu_alloc, fu_done
    );
endinterface

// File: rtl/pe_fu_multi_alu.sv
// Combinational ALU shared by the streaming and accumulate paths.
// Latency: 0 cycles. Backpressure: none, pure function of its inputs.
// Opcode 12 multiplies only when PE_FU_MUL_EN is defined.
module pe_fu_alu
    import pe_fu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  fu_op_e                i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_pred,
    output logic [DATA_WIDTH-1:0] o_result
);
    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [SH_W-1:0] w_shamt;
    assign w_shamt = i_b[SH_W-1:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD: o_result = i_a + i_b;
            OP_SUB: o_result = i_a - i_b;
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_SHL: o_result = i_a << w_shamt;
            OP_SRL: o_result = i_a >> w_shamt;
            OP_SRA: o_result = $unsigned($signed(i_a) >>> w_shamt);
            OP_LT:  o_result[0] = ($signed(i_a) < $signed(i_b));
            OP_LTU: o_result[0] = (i_a < i_b);
            OP_EQ:  o_result[0] = (i_a == i_b);
            OP_SEL: o_result = i_pred ? i_a : i_b;
`ifdef PE_FU_MUL_EN
            OP_MUL: o_result = i_a * i_b;
`endif
            default: o_result = '0;
        endcase
    end
endmodule

// File: rtl/pe_fu_multi.sv
// RipTide PE functional unit: configurable op over NUM_IN channels, optional accumulate, OUT_DEPTH result buffer.
// Latency: result on fu_out the cycle after fire. Backpressure: fire stalls while the buffer is full.
// PE_FU_MUL_EN adds a single-cycle multiply for opcode 12.
module pe_fu_multi
    import pe_fu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 3,
    parameter int OUT_DEPTH  = 2
) (
    input logic          clk,
    input logic          rst,
    pe_fu_multi_if.slave bus
);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int CFG_W = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUT_DEPTH);

    fu_state_e             r_state, w_state_nxt;
    cfg_t                  r_cfg, w_cfg_new;
    logic                  r_cfg_err;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_buf_dat [OUT_DEPTH];
    logic [OUT_DEPTH-1:0]  r_buf_last;
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [CFG_W-1:0]        w_cfg_ext;
    logic [3*DATA_WIDTH-1:0] w_data_ext;
    logic [2:0]              w_vld3, w_use3;
    logic [DATA_WIDTH-1:0]   w_ch0, w_ch1, w_imm_sext, w_new_imm_sext;
    logic [DATA_WIDTH-1:0]   w_alu_a, w_alu_b, w_result;
    logic w_pred, w_new_legal, w_space, w_go, w_fire, w_push, w_pop, w_unused;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Zero-extend to three channels so NUM_IN=2 needs no separate indexing paths.
    assign w_cfg_ext  = CFG_W'(bus.cfg);
    assign w_data_ext = (3*DATA_WIDTH)'(bus.in_data);
    assign w_vld3     = 3'(bus.in_valid);
    assign w_ch0      = w_data_ext[0 +: DATA_WIDTH];
    assign w_ch1      = w_data_ext[DATA_WIDTH +: DATA_WIDTH];
    assign w_pred     = w_data_ext[2*DATA_WIDTH];

    always_comb begin
        w_cfg_new        = '0;
        w_cfg_new.op     = fu_op_e'(w_cfg_ext[CFG_OP_LSB +: CFG_OP_WIDTH]);
        w_cfg_new.imm_en = w_cfg_ext[CFG_IMM_EN_BIT];
        w_cfg_new.acc_en = w_cfg_ext[CFG_ACC_EN_BIT];
        w_cfg_new.imm    = w_cfg_ext[CFG_IMM_LSB +: IMM_WIDTH];
    end

    assign w_new_legal    = op_legal(w_cfg_new.op);
    assign w_imm_sext     = DATA_WIDTH'($signed(r_cfg.imm));
    assign w_new_imm_sext = DATA_WIDTH'($signed(w_cfg_new.imm));

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_UNCFG;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.cfg_valid) w_state_nxt = w_new_legal ? ST_RUN : ST_UNCFG;
    end

    // Channels that must all be valid for one normal-mode fire.
    always_comb begin
        w_use3    = 3'b001;
        w_use3[1] = ~r_cfg.acc_en & ~r_cfg.imm_en;
        w_use3[2] = ~r_cfg.acc_en & (r_cfg.op == OP_SEL) & (NUM_IN == 3);
    end

    assign w_space = (r_count < DEPTH_C);
    assign w_go    = (r_state == ST_RUN) & ~bus.cfg_valid & ~bus.clear;
    assign w_fire  = w_go & (r_cfg.acc_en ? (w_vld3[0] & (~bus.in_last | w_space))
                                          : (((w_vld3 & w_use3) == w_use3) & w_space));
    assign w_push  = w_fire & (~r_cfg.acc_en | bus.in_last);
    assign w_pop   = (r_count != '0) & bus.out_ready;

    assign w_alu_a = r_cfg.acc_en ? r_acc : w_ch0;
    assign w_alu_b = r_cfg.acc_en ? w_ch0 : (r_cfg.imm_en ? w_imm_sext : w_ch1);

    pe_fu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .i_op     (r_cfg.op),
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_pred   (w_pred),
        .o_result (w_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg     <= '0;
            r_cfg_err <= 1'b0;
        end else if (bus.cfg_valid) begin
            r_cfg     <= w_cfg_new;
            r_cfg_err <= ~w_new_legal;
        end
    end

    // A cfg load outranks clear so the freshly loaded immediate seeds the accumulator.
    always_ff @(posedge clk) begin
        if (rst)                         r_acc <= '0;
        else if (bus.cfg_valid)          r_acc <= w_new_imm_sext;
        else if (bus.clear)              r_acc <= w_imm_sext;
        else if (w_fire & r_cfg.acc_en)  r_acc <= w_push ? w_imm_sext : w_result;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_buf_last <= '0;
        end else begin
            if (w_push) begin
                r_buf_last[r_wr_ptr] <= bus.in_last;
                r_wr_ptr             <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_buf_dat[r_wr_ptr] <= w_result;
    end

    assign bus.fu_ready = w_fire ? w_use3[NUM_IN-1:0] : '0;
    assign bus.fu_alloc = w_push;
    assign bus.fu_valid = (r_count != '0);
    assign bus.fu_out   = (r_count != '0) ? r_buf_dat[r_rd_ptr] : '0;
    assign bus.fu_done  = w_pop & r_buf_last[r_rd_ptr] & ~bus.clear;
    assign bus.cfg_err  = r_cfg_err;

    assign w_unused = ^{w_cfg_ext, w_data_ext};
endmodule

// File: tb/tb_pe_fu_multi.sv
// Scoreboarded bench for pe_fu_multi: per-feature tasks with inline checks, monitor pops expected results.
module tb_pe_fu_multi;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;

    pe_fu_multi_if #(.DATA_WIDTH(DW), .NUM_IN(3)) bus ();

    pe_fu_multi #(.DATA_WIDTH(DW), .NUM_IN(3), .OUT_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        p;
        logic [31:0] r;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Every pop is compared against the oldest expected commit.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && bus.fu_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL mon_pop unexpected result got=%h", bus.fu_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.fu_out !== e.d || bus.fu_done !== (e.last & ~bus.clear)) begin
                    failures++;
                    $display("FAIL mon_pop got=%h done=%b exp=%h done=%b", bus.fu_out, bus.fu_done, e.d, e.last & ~bus.clear);
                end
            end
        end
    end

    task automatic drive(input logic [2:0] v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic last, input logic ordy);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.clear     = 1'b0;
        bus.in_valid  = v;
        bus.in_data   = {d2, d1, d0};
        bus.in_last   = last;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, ordy);
    endtask

    task automatic load_cfg(input logic [3:0] op, input logic imm_en, input logic acc_en, input logic [15:0] imm);
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg       = {imm, 10'd0, acc_en, imm_en, op};
        bus.clear     = 1'b0;
        bus.in_valid  = 3'b000;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cfg_valid = 1'b0; bus.cfg = '0; bus.clear = 1'b0; bus.in_valid = 3'b111;
        bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.cfg_err, bus.fu_valid, bus.fu_alloc, bus.fu_done, bus.fu_ready, bus.fu_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got err=%b vld=%b alloc=%b done=%b rdy=%b out=%h exp all 0",
                     bus.cfg_err, bus.fu_valid, bus.fu_alloc, bus.fu_done, bus.fu_ready, bus.fu_out);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(3'b111, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1);
        checks++;
        if (bus.fu_ready !== 3'b000) begin
            failures++;
            $display("FAIL uncfg_ready got=%b exp=000", bus.fu_ready);
        end
    endtask

    task automatic test_add();
        load_cfg(4'd0, 1'b0, 1'b0, 16'd0);
        drive(3'b011, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1);
        checks++;
        if (bus.fu_ready !== 3'b011 || bus.fu_alloc !== 1'b1) begin
            failures++;
            $display("FAIL add_fire rdy=%b alloc=%b exp 011/1", bus.fu_ready, bus.fu_alloc);
        end
        exp_q.push_back('{32'd12, 1'b0});
        idle(1'b1);
        checks++;
        if (bus.fu_valid !== 1'b1 || bus.fu_out !== 32'd12) begin
            failures++;
            $display("FAIL add_latency vld=%b out=%h exp 1/0000000c", bus.fu_valid, bus.fu_out);
        end
    endtask

    task automatic test_sub_imm();
        load_cfg(4'd1, 1'b1, 1'b0, 16'hFFFF);
        drive(3'b011, 32'd3, 32'd99, 32'd0, 1'b0, 1'b1);
        checks++;
        if (bus.fu_ready !== 3'b001 || bus.fu_alloc !== 1'b1) begin
            failures++;
            $display("FAIL sub_imm_ready rdy=%b alloc=%b exp 001/1", bus.fu_ready, bus.fu_alloc);
        end
        exp_q.push_back('{32'd4, 1'b0});
        idle(1'b1);
    endtask

    task automatic test_ops();
        vec_t v[14];
        logic [2:0] exp_rdy;
        v[0]  = '{4'd1,  32'd3,          32'd5,          1'b0, 32'hFFFF_FFFE};
        v[1]  = '{4'd2,  32'hF0F0_F0F0,  32'hFF00_FF00,  1'b0, 32'hF000_F000};
        v[2]  = '{4'd3,  32'h0F,         32'hF0,         1'b0, 32'hFF};
        v[3]  = '{4'd4,  32'hFF,         32'h0F,         1'b0, 32'hF0};
        v[4]  = '{4'd5,  32'd1,          32'd4,          1'b0, 32'd16};
        v[5]  = '{4'd5,  32'd3,          32'd33,         1'b0, 32'd6};
        v[6]  = '{4'd6,  32'h8000_0000,  32'd4,          1'b0, 32'h0800_0000};
        v[7]  = '{4'd7,  32'h8000_0000,  32'd4,          1'b0, 32'hF800_0000};
        v[8]  = '{4'd8,  32'hFFFF_FFFF,  32'd1,          1'b0, 32'd1};
        v[9]  = '{4'd9,  32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0};
        v[10] = '{4'd10, 32'd5,          32'd5,          1'b0, 32'd1};
        v[11] = '{4'd11, 32'd11,         32'd22,         1'b1, 32'd11};
        v[12] = '{4'd11, 32'd11,         32'd22,         1'b0, 32'd22};
        v[13] = '{4'd0,  32'hFFFF_FFFF,  32'd2,          1'b0, 32'd1};
        foreach (v[i]) begin
            load_cfg(v[i].op, 1'b0, 1'b0, 16'd0);
            drive(3'b111, v[i].a, v[i].b, {31'd0, v[i].p}, 1'b0, 1'b1);
            exp_rdy = (v[i].op == 4'd11) ? 3'b111 : 3'b011;
            checks++;
            if (bus.fu_ready !== exp_rdy || bus.fu_alloc !== 1'b1) begin
                failures++;
                $display("FAIL ops_fire[%0d] rdy=%b alloc=%b exp %b/1", i, bus.fu_ready, bus.fu_alloc, exp_rdy);
            end
            exp_q.push_back('{v[i].r, 1'b0});
        end
        idle(1'b1);
    endtask

    task automatic test_accumulate();
        load_cfg(4'd0, 1'b0, 1'b1, 16'd0);
        for (int k = 1; k <= 3; k++) begin
            drive(3'b011, 32'(k), 32'd50, 32'd0, (k == 3), 1'b1);
            checks++;
            if (bus.fu_ready !== 3'b001 || bus.fu_alloc !== (k == 3)) begin
                failures++;
                $display("FAIL acc_step[%0d] rdy=%b alloc=%b exp 001/%b", k, bus.fu_ready, bus.fu_alloc, (k == 3));
            end
        end
        exp_q.push_back('{32'd6, 1'b1});
        idle(1'b1);
        checks++;
        if (bus.fu_out !== 32'd6 || bus.fu_done !== 1'b1) begin
            failures++;
            $display("FAIL acc_done out=%h done=%b exp 00000006/1", bus.fu_out, bus.fu_done);
        end
        drive(3'b001, 32'd10, 32'd0, 32'd0, 1'b1, 1'b1);
        exp_q.push_back('{32'd10, 1'b1});
        // Seed from a negative immediate: -10 + 4.
        load_cfg(4'd0, 1'b0, 1'b1, 16'hFFF6);
        drive(3'b001, 32'd4, 32'd0, 32'd0, 1'b1, 1'b1);
        exp_q.push_back('{32'hFFFF_FFFA, 1'b1});
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic test_back_to_back();
        load_cfg(4'd0, 1'b0, 1'b0, 16'd0);
        drive(3'b011, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
        exp_q.push_back('{32'd2, 1'b0});
        drive(3'b011, 32'd2, 32'd2, 32'd0, 1'b0, 1'b0);
        exp_q.push_back('{32'd4, 1'b0});
        drive(3'b011, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
        checks++;
        if (bus.fu_ready !== 3'b000 || bus.fu_alloc !== 1'b0) begin
            failures++;
            $display("FAIL full_stall rdy=%b alloc=%b exp 000/0", bus.fu_ready, bus.fu_alloc);
        end
        drive(3'b011, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
        checks++;
        if (bus.fu_ready !== 3'b000) begin
            failures++;
            $display("FAIL pop_no_free rdy=%b exp 000", bus.fu_ready);
        end
        drive(3'b011, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
        checks++;
        if (bus.fu_ready !== 3'b011 || bus.fu_alloc !== 1'b1) begin
            failures++;
            $display("FAIL after_pop rdy=%b alloc=%b exp 011/1", bus.fu_ready, bus.fu_alloc);
        end
        exp_q.push_back('{32'd6, 1'b0});
        for (int k = 0; k < 4; k++) begin
            drive(3'b011, 32'(10 + k), 32'd100, 32'd0, 1'b0, 1'b1);
            checks++;
            if (bus.fu_alloc !== 1'b1) begin
                failures++;
                $display("FAIL throughput[%0d] alloc=%b exp 1", k, bus.fu_alloc);
            end
            exp_q.push_back('{32'(110 + k), 1'b0});
        end
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic test_cfg_err();
        load_cfg(4'd13, 1'b0, 1'b0, 16'd0);
        drive(3'b011, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);
        checks++;
        if (bus.cfg_err !== 1'b1 || bus.fu_ready !== 3'b000 || bus.fu_alloc !== 1'b0) begin
            failures++;
            $display("FAIL illegal13 err=%b rdy=%b alloc=%b exp 1/000/0", bus.cfg_err, bus.fu_ready, bus.fu_alloc);
        end
        load_cfg(4'd0, 1'b0, 1'b0, 16'd0);
        drive(3'b011, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1);
        checks++;
        if (bus.cfg_err !== 1'b0 || bus.fu_alloc !== 1'b1) begin
            failures++;
            $display("FAIL legal_reload err=%b alloc=%b exp 0/1", bus.cfg_err, bus.fu_alloc);
        end
        exp_q.push_back('{32'd5, 1'b0});
        load_cfg(4'd14, 1'b0, 1'b0, 16'd0);
        drive(3'b011, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);
        checks++;
        if (bus.cfg_err !== 1'b1 || bus.fu_ready !== 3'b000) begin
            failures++;
            $display("FAIL run_to_uncfg err=%b rdy=%b exp 1/000", bus.cfg_err, bus.fu_ready);
        end
        load_cfg(4'd12, 1'b0, 1'b0, 16'd0);
        drive(3'b011, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1);
        checks++;
`ifdef PE_FU_MUL_EN
        if (bus.cfg_err !== 1'b0 || bus.fu_alloc !== 1'b1) begin
            failures++;
            $display("FAIL mul_cfg err=%b alloc=%b exp 0/1", bus.cfg_err, bus.fu_alloc);
        end
        exp_q.push_back('{32'd42, 1'b0});
`else
        if (bus.cfg_err !== 1'b1 || bus.fu_ready !== 3'b000) begin
            failures++;
            $display("FAIL mul_cfg err=%b rdy=%b exp 1/000", bus.cfg_err, bus.fu_ready);
        end
`endif
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic test_clear();
        load_cfg(4'd0, 1'b0, 1'b1, 16'd0);
        drive(3'b001, 32'd4, 32'd0, 32'd0, 1'b1, 1'b0);
        exp_q.push_back('{32'd4, 1'b1});
        drive(3'b001, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0);
        drive(3'b001, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (bus.fu_ready !== 3'b001 || bus.fu_alloc !== 1'b0) begin
            failures++;
            $display("FAIL acc_full_nolast rdy=%b alloc=%b exp 001/0", bus.fu_ready, bus.fu_alloc);
        end
        // Head pops during clear but its done pulse must be masked.
        @(negedge clk);
        bus.clear = 1'b1; bus.in_valid = 3'b001; bus.in_data = {32'd0, 32'd0, 32'd3};
        bus.in_last = 1'b1; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.fu_ready !== 3'b000 || bus.fu_alloc !== 1'b0) begin
            failures++;
            $display("FAIL clear_block rdy=%b alloc=%b exp 000/0", bus.fu_ready, bus.fu_alloc);
        end
        drive(3'b001, 32'd1, 32'd0, 32'd0, 1'b1, 1'b1);
        checks++;
        if (bus.fu_valid !== 1'b0 || bus.fu_alloc !== 1'b1) begin
            failures++;
            $display("FAIL clear_flush vld=%b alloc=%b exp 0/1", bus.fu_valid, bus.fu_alloc);
        end
        exp_q.push_back('{32'd1, 1'b1});
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic test_rst_mid();
        load_cfg(4'd0, 1'b0, 1'b0, 16'd0);
        drive(3'b011, 32'd8, 32'd8, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; bus.in_valid = 3'b011;
        #1;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.cfg_err, bus.fu_valid, bus.fu_alloc, bus.fu_done, bus.fu_ready, bus.fu_out} !== '0) begin
            failures++;
            $display("FAIL rst_mid vld=%b out=%h rdy=%b exp all 0", bus.fu_valid, bus.fu_out, bus.fu_ready);
        end
        rst = 1'b0;
        drive(3'b011, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);
        checks++;
        if (bus.fu_ready !== 3'b000 || bus.fu_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_uncfg rdy=%b vld=%b exp 000/0", bus.fu_ready, bus.fu_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_imm();
        test_ops();
        test_accumulate();
        test_back_to_back();
        test_cfg_err();
        test_clear();
        test_rst_mid();
        repeat (3) idle(1'b1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
